pll_cfg_handshake: RTL and testbench

Request/acknowledge initiator driving the PLL reconfiguration interface from the AHB clock domain. Consumes the single-cycle start pulse produced from the software trigger bit, raises a level request toward the PLL and holds it until the PLL acknowledges. It then completes a full four-phase return-to-zero handshake and reports completion or timeout back to the register block. Sits between the register-bank trigger logic and the PLL controller.

---
 rtl/pll_cfg_handshake.sv | 201 ++++++++++++++++++++
 tb/tb_pll_cfg_handshake.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_cfg_handshake.sv
// -----------------------------------------------------------------------------
// pll_cfg_handshake
//
// Four-phase return-to-zero request/acknowledge initiator that drives the PLL
// reconfiguration interface from the AHB clock domain.
//
// Handshake (all in i_clk_ahb domain, ack synchronized first):
//   o_pll_req rises on an accepted start, stays high until the synchronized
//   ack is seen high, then falls; the transfer completes (o_done) once the
//   synchronized ack is seen low again.  o_pll_req never changes while the
//   previous phase is still open, so the PLL always sees a clean level.
//
// Configuration macro:
//   PLL_HS_TIMEOUT_EN  defined   : per-phase timeout counter and abort path,
//                                  o_timeout pulses on an aborted handshake.
//                      undefined : no counter, o_timeout tied low, phases
//                                  wait indefinitely (only reset aborts).
//
// Parameters:
//   TIMEOUT_CYCLES  cycles allowed in each waiting phase (>= 2)
//   SYNC_STAGES     synchronizer depth on i_pll_ack (>= 2)
//
// Ports:
//   i_clk_ahb     AHB clock, the only clock
//   i_rstn_ahb    asynchronous active-low reset
//   i_start       single-cycle start pulse from the trigger edge detector
//   i_pll_ack     PLL acknowledge, asynchronous to i_clk_ahb
//   o_pll_req     level request to the PLL
//   o_busy        high whenever the FSM is not idle
//   o_trig_clr    one-cycle pulse clearing the software trigger bit
//   o_done        one-cycle pulse on a completed handshake
//   o_timeout     one-cycle pulse on an aborted handshake
//   o_start_drop  one-cycle pulse when i_start arrives while busy
//   o_dbg_state   current FSM state (0 idle, 1 req, 2 rel) for observation
// -----------------------------------------------------------------------------
module pll_cfg_handshake #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       i_clk_ahb,
  input  logic       i_rstn_ahb,
  input  logic       i_start,
  input  logic       i_pll_ack,
  output logic       o_pll_req,
  output logic       o_busy,
  output logic       o_trig_clr,
  output logic       o_done,
  output logic       o_timeout,
  output logic       o_start_drop,
  output logic [1:0] o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2
  } state_t;

  // Elaboration-time guard on the legal parameter ranges.
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("pll_cfg_handshake: SYNC_STAGES must be >= 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout_cycles
    $error("pll_cfg_handshake: TIMEOUT_CYCLES must be >= 2");
  end

  // ---------------------------------------------------------------------------
  // Acknowledge synchronizer; only the last stage is used by the FSM.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_ack_sync;
  logic                   w_ack_s;

  always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
    if (!i_rstn_ahb) begin
      r_ack_sync <= '0;
    end else begin
      r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], i_pll_ack};
    end
  end

  assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // FSM state register and registered outputs
  // ---------------------------------------------------------------------------
  state_t r_state;
  state_t w_state_next;
  logic   w_expire;
  logic   w_trig_clr_next;
  logic   w_done_next;
  logic   w_timeout_next;
  logic   w_start_drop_next;
  logic   r_pll_req;
  logic   r_busy;
  logic   r_trig_clr;
  logic   r_done;
  logic   r_start_drop;

  always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
    if (!i_rstn_ahb) begin
      r_state      <= ST_IDLE;
      r_pll_req    <= 1'b0;
      r_busy       <= 1'b0;
      r_trig_clr   <= 1'b0;
      r_done       <= 1'b0;
      r_start_drop <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_pll_req    <= (w_state_next == ST_REQ);
      r_busy       <= (w_state_next != ST_IDLE);
      r_trig_clr   <= w_trig_clr_next;
      r_done       <= w_done_next;
      r_start_drop <= w_start_drop_next;
    end
  end

  // Next-state logic.  In each waiting phase the exit condition is tested
  // before the timeout, so an exit and an expiry on the same edge complete
  // normally.  A start seen outside IDLE (including on the edge that returns
  // to IDLE) is reported and otherwise ignored.
  always_comb begin
    w_state_next      = r_state;
    w_trig_clr_next   = 1'b0;
    w_done_next       = 1'b0;
    w_timeout_next    = 1'b0;
    w_start_drop_next = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_next    = ST_REQ;
          w_trig_clr_next = 1'b1;
        end
      end
      ST_REQ: begin
        w_start_drop_next = i_start;
        if (w_ack_s) begin
          w_state_next = ST_REL;
        end else if (w_expire) begin
          w_state_next   = ST_IDLE;
          w_timeout_next = 1'b1;
        end
      end
      ST_REL: begin
        w_start_drop_next = i_start;
        if (!w_ack_s) begin
          w_state_next = ST_IDLE;
          w_done_next  = 1'b1;
        end else if (w_expire) begin
          w_state_next   = ST_IDLE;
          w_timeout_next = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

`ifdef PLL_HS_TIMEOUT_EN
  // ---------------------------------------------------------------------------
  // Per-phase timeout counter: cleared on every state change, counts cycles
  // spent in REQ or REL, saturates at TIMEOUT_CYCLES.
  // ---------------------------------------------------------------------------
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] C_MAX  = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] r_cnt;
  logic          r_timeout;

  always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
    if (!i_rstn_ahb) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_timeout_next;
      if (w_state_next != r_state) begin
        r_cnt <= '0;
      end else if ((r_state != ST_IDLE) && (r_cnt != C_MAX)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign w_expire  = (r_cnt == C_LAST);
  assign o_timeout = r_timeout;
`else
  logic w_timeout_unused;
  assign w_timeout_unused = w_timeout_next;
  assign w_expire  = 1'b0;
  assign o_timeout = 1'b0;
`endif

  assign o_pll_req    = r_pll_req;
  assign o_busy       = r_busy;
  assign o_trig_clr   = r_trig_clr;
  assign o_done       = r_done;
  assign o_start_drop = r_start_drop;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_pll_cfg_handshake.sv
// -----------------------------------------------------------------------------
// tb_pll_cfg_handshake
//
// Directed bench for pll_cfg_handshake with TIMEOUT_CYCLES=16, SYNC_STAGES=2.
// The timeout scenarios are built when PLL_HS_TIMEOUT_EN is defined; without
// it the "no ack for 100 cycles" scenario runs instead.
//
// Cycle numbering: "cycle k" is the interval just after rising edge k.
// Inputs are driven and outputs sampled 1 time unit after a rising edge, so
// an input set in cycle k is sampled by the DUT at edge k+1.
// -----------------------------------------------------------------------------
module tb_pll_cfg_handshake;

  logic       i_clk_ahb;
  logic       i_rstn_ahb;
  logic       i_start;
  logic       i_pll_ack;
  logic       o_pll_req;
  logic       o_busy;
  logic       o_trig_clr;
  logic       o_done;
  logic       o_timeout;
  logic       o_start_drop;
  logic [1:0] o_dbg_state;

  int checks   = 0;
  int failures = 0;
  int done_cnt;

  pll_cfg_handshake #(
    .TIMEOUT_CYCLES(16),
    .SYNC_STAGES   (2)
  ) dut (
    .i_clk_ahb   (i_clk_ahb),
    .i_rstn_ahb  (i_rstn_ahb),
    .i_start     (i_start),
    .i_pll_ack   (i_pll_ack),
    .o_pll_req   (o_pll_req),
    .o_busy      (o_busy),
    .o_trig_clr  (o_trig_clr),
    .o_done      (o_done),
    .o_timeout   (o_timeout),
    .o_start_drop(o_start_drop),
    .o_dbg_state (o_dbg_state)
  );

  // clock / reset
  initial i_clk_ahb = 1'b0;
  always #5 i_clk_ahb = ~i_clk_ahb;

  // driver tasks
  task automatic tick();
    @(posedge i_clk_ahb);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    i_rstn_ahb = 1'b0;
    i_start    = 1'b0;
    i_pll_ack  = 1'b0;
    tick();
    tick();
    i_rstn_ahb = 1'b1;
    tick();
    tick();
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"},   {7'd0, o_pll_req},    8'd0);
    chk({tag, "_busy"},  {7'd0, o_busy},       8'd0);
    chk({tag, "_trig"},  {7'd0, o_trig_clr},   8'd0);
    chk({tag, "_done"},  {7'd0, o_done},       8'd0);
    chk({tag, "_to"},    {7'd0, o_timeout},    8'd0);
    chk({tag, "_drop"},  {7'd0, o_start_drop}, 8'd0);
    chk({tag, "_state"}, {6'd0, o_dbg_state},  8'd0);
  endtask

  initial begin
    // ---------------- reset check ----------------
    i_rstn_ahb = 1'b0;
    i_start    = 1'b0;
    i_pll_ack  = 1'b0;
    tick();
    tick();
    chk_all_zero("rst_hold");
    i_rstn_ahb = 1'b1;
    tick();
    chk_all_zero("rst_rel");
    // an ack pulse on its own must not wake anything up
    i_pll_ack = 1'b1;
    tick();
    i_pll_ack = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("ackonly_req",  {7'd0, o_pll_req}, 8'd0);
      chk("ackonly_busy", {7'd0, o_busy},    8'd0);
      chk("ackonly_done", {7'd0, o_done},    8'd0);
      tick();
    end
    chk_all_zero("ackonly_end");

    // ---------------- nominal handshake ----------------
    // PLL model: ack high in cycles 4..8 (rises 3 cycles after req rises in
    // cycle 1, falls while req has been low since cycle 7).
    // Expected: trig_clr cycle 1, req cycles 1..6, done cycle 12, busy 1..11.
    do_reset();
    done_cnt = 0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      i_pll_ack = (c >= 4) && (c <= 8);
      chk("nom_req",  {7'd0, o_pll_req},  {7'd0, 1'(c <= 6)});
      chk("nom_trig", {7'd0, o_trig_clr}, {7'd0, 1'(c == 1)});
      chk("nom_done", {7'd0, o_done},     {7'd0, 1'(c == 12)});
      chk("nom_busy", {7'd0, o_busy},     {7'd0, 1'(c <= 11)});
      chk("nom_to",   {7'd0, o_timeout},  8'd0);
      if (o_done) done_cnt++;
      tick();
    end
    chk("nom_done_count", 8'(done_cnt), 8'd1);
    chk("nom_state_idle", {6'd0, o_dbg_state}, 8'd0);

`ifdef PLL_HS_TIMEOUT_EN
    // ---------------- timeout in REQ ----------------
    // req rises cycle 1; counter reaches 15 after edge 16; abort at edge 17.
    do_reset();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      chk("toreq_req",  {7'd0, o_pll_req}, {7'd0, 1'(c <= 16)});
      chk("toreq_to",   {7'd0, o_timeout}, {7'd0, 1'(c == 17)});
      chk("toreq_busy", {7'd0, o_busy},    {7'd0, 1'(c <= 16)});
      chk("toreq_done", {7'd0, o_done},    8'd0);
      if (c == 17) i_start = 1'b1;
      tick();
    end
    i_start = 1'b0;
    chk("toreq_restart_req",  {7'd0, o_pll_req},  8'd1);
    chk("toreq_restart_trig", {7'd0, o_trig_clr}, 8'd1);
    chk("toreq_restart_st",   {6'd0, o_dbg_state}, 8'd1);

    // ---------------- timeout in REL ----------------
    // ack high from cycle 0: sampled edge 1, ack_s after edge 2, REL at edge 3.
    // REL entered at edge 3, abort at edge 19.
    do_reset();
    i_start   = 1'b1;
    i_pll_ack = 1'b1;
    tick();
    i_start = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      chk("torel_req",  {7'd0, o_pll_req}, {7'd0, 1'(c <= 2)});
      chk("torel_to",   {7'd0, o_timeout}, {7'd0, 1'(c == 19)});
      chk("torel_busy", {7'd0, o_busy},    {7'd0, 1'(c <= 18)});
      chk("torel_done", {7'd0, o_done},    8'd0);
      tick();
    end
    i_pll_ack = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("torel_after_done", {7'd0, o_done}, 8'd0);
      tick();
    end
`else
    // ---------------- no timeout build: waits forever ----------------
    do_reset();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      chk("noto_req", {7'd0, o_pll_req}, 8'd1);
      chk("noto_to",  {7'd0, o_timeout}, 8'd0);
      tick();
    end
    chk("noto_state", {6'd0, o_dbg_state}, 8'd1);
`endif

    // ---------------- busy start ----------------
    // Same PLL model as nominal.  Starts in cycle 3 (REQ, sampled edge 4) and
    // in cycle 11 (sampled at edge 12, the edge that completes) are dropped.
    do_reset();
    done_cnt = 0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      i_pll_ack = (c >= 4) && (c <= 8);
      chk("busy_drop", {7'd0, o_start_drop}, {7'd0, 1'((c == 4) || (c == 12))});
      chk("busy_done", {7'd0, o_done},       {7'd0, 1'(c == 12)});
      chk("busy_req",  {7'd0, o_pll_req},    {7'd0, 1'(c <= 6)});
      chk("busy_trig", {7'd0, o_trig_clr},   {7'd0, 1'(c == 1)});
      if (o_done) done_cnt++;
      i_start = (c == 3) || (c == 11);
      tick();
    end
    chk("busy_done_count", 8'(done_cnt), 8'd1);
    chk("busy_idle_busy",  {7'd0, o_busy}, 8'd0);

    // ---------------- mid-operation reset ----------------
    do_reset();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    tick();
    chk("mid_req_before", {7'd0, o_pll_req}, 8'd1);
    i_rstn_ahb = 1'b0;
    #1;
    chk_all_zero("mid_async");
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("mid_hold_done", {7'd0, o_done},    8'd0);
      chk("mid_hold_to",   {7'd0, o_timeout}, 8'd0);
    end
    i_rstn_ahb = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("mid_after_done", {7'd0, o_done},    8'd0);
      chk("mid_after_to",   {7'd0, o_timeout}, 8'd0);
      chk("mid_after_req",  {7'd0, o_pll_req}, 8'd0);
    end

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
